// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared register map, FSM states and default cause codes for int_ctrl
package int_pkg;

  localparam logic [1:0] INT_MASK   = 2'd0;
  localparam logic [1:0] INT_PEND   = 2'd1;
  localparam logic [1:0] INT_STATUS = 2'd2;
  localparam logic [1:0] INT_CAUSE  = 2'd3;

  localparam int DEF_CAUSE_BASE = 16;
  localparam int DEF_SW_CAUSE   = 8;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder with valid flag
module int_prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - prioritised, maskable interrupt controller with req/ack/eret handshake
module int_ctrl
  import int_pkg::*;
#(
  parameter int              N_CH       = 8,
  parameter int              SYNC       = 2,
  parameter logic [N_CH-1:0] EDGE       = {N_CH{1'b1}},
  parameter int              CAUSE_BASE = DEF_CAUSE_BASE,
  parameter int              SW_CAUSE   = DEF_SW_CAUSE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq,
  input  logic            sw_req,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            int_req,
  output logic [31:0]     int_cause,
  input  logic            int_ack,
  input  logic            eret
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] sync_q [SYNC];
  logic [N_CH-1:0] irq_s, irq_d, rise;
  logic [N_CH-1:0] pend_q, mask_q, elig, clr, pend_nxt;
  logic            swpend_q, gie_q, win_sw_q;
  logic [IW-1:0]   win_idx_q, enc_idx;
  logic            enc_valid;
  logic [31:0]     cause_q;
  int_state_e      state_q, state_d;
  logic            take, accept, finish;
  logic            wr_mask, wr_pend, wr_status;
  logic            unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign irq_s = sync_q[SYNC-1];
  assign rise  = irq_s & ~irq_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
      irq_d <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      irq_d <= irq_s;
    end
  end

  assign wr_mask   = cfg_we && (cfg_addr == INT_MASK);
  assign wr_pend   = cfg_we && (cfg_addr == INT_PEND);
  assign wr_status = cfg_we && (cfg_addr == INT_STATUS);

  assign elig = pend_q & mask_q;

  int_prio_enc #(.N(N_CH), .W(IW)) u_enc (
    .req   (elig),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gie_q && (swpend_q || enc_valid)) begin
          state_d = REQ;
          take    = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
          accept  = 1'b1;
        end else if (!gie_q || (wr_status && !cfg_wdata[0])) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set events are OR-ed in after clears so a same-cycle edge survives a W1C or ack.
  always_comb begin
    clr = wr_pend ? cfg_wdata[N_CH-1:0] : '0;
    if (accept && !win_sw_q) clr[win_idx_q] = 1'b1;
  end

  assign pend_nxt = (EDGE & ((pend_q & ~clr) | rise)) | (~EDGE & irq_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      swpend_q  <= 1'b0;
      gie_q     <= 1'b0;
      win_sw_q  <= 1'b0;
      win_idx_q <= '0;
      cause_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_nxt;
      swpend_q <= sw_req | (swpend_q & ~(accept & win_sw_q));
      if (wr_mask) mask_q <= cfg_wdata[N_CH-1:0];
      if (accept)         gie_q <= 1'b0;
      else if (finish)    gie_q <= 1'b1;
      else if (wr_status) gie_q <= cfg_wdata[0];
      if (take) begin
        win_sw_q  <= swpend_q;
        win_idx_q <= enc_idx;
        cause_q   <= swpend_q ? 32'(SW_CAUSE) : 32'(CAUSE_BASE) + 32'(enc_idx);
      end
    end
  end

  assign int_req   = (state_q == REQ);
  assign int_cause = cause_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      INT_MASK:   cfg_rdata = 32'(mask_q);
      INT_PEND:   cfg_rdata = 32'(pend_q);
      INT_STATUS: cfg_rdata = {31'b0, gie_q};
      INT_CAUSE:  cfg_rdata = cause_q;
      default:    cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        sw_req, cfg_we, int_ack, eret;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata, int_cause;
  logic        int_req;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  int_ctrl #(.N_CH(8), .SYNC(2), .EDGE(8'hF7)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .sw_req    (sw_req),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_req   (int_req),
    .int_cause (int_cause),
    .int_ack   (int_ack),
    .eret      (eret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] want);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, want);
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq = '0; sw_req = 0; cfg_we = 0; int_ack = 0; eret = 0;
    cfg_addr = 2'd0; cfg_wdata = '0;
    tick(3);
    check("rst_req", {31'b0, int_req}, 0);
    check("rst_cause", int_cause, 0);
    rd("rst_mask", 2'd0, 0);
    rd("rst_pend", 2'd1, 0);
    rd("rst_status", 2'd2, 0);
    rst = 1'b1;
    tick();
    do_eret();
    rd("eret_idle_ignored", 2'd2, 0);

    // Single edge source on channel 0
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h01);
    irq[0] = 1'b1;
    tick(3);
    check("ch0_req_early", {31'b0, int_req}, 0);
    tick();
    check("ch0_req", {31'b0, int_req}, 1);
    check("ch0_cause", int_cause, 16);
    rd("cause_reg", 2'd3, 16);
    ack();
    check("ch0_req_drop", {31'b0, int_req}, 0);
    rd("ch0_gie_clr", 2'd2, 0);
    rd("ch0_pend_clr", 2'd1, 0);
    irq[0] = 1'b0;
    do_eret();
    rd("ch0_gie_set", 2'd2, 1);
    tick();
    check("ch0_idle", {31'b0, int_req}, 0);

    // Simultaneous channels 5 and 2
    wr(2'd0, 32'hFF);
    irq = 8'h24;
    tick(4);
    check("c2_req", {31'b0, int_req}, 1);
    check("c2_cause", int_cause, 18);
    ack();
    rd("c5_still_pend", 2'd1, 32'h20);
    do_eret();
    check("c5_not_yet", {31'b0, int_req}, 0);
    tick();
    check("c5_req", {31'b0, int_req}, 1);
    check("c5_cause", int_cause, 21);
    ack();
    do_eret();
    tick();
    check("c5_done", {31'b0, int_req}, 0);
    irq = '0;

    // Software request beats a same-cycle channel 0 edge
    irq[0] = 1'b1; sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick();
    check("sw_req", {31'b0, int_req}, 1);
    check("sw_cause", int_cause, 8);
    ack();
    do_eret();
    tick();
    check("sw_then_c0", {31'b0, int_req}, 1);
    check("sw_then_c0_cause", int_cause, 16);
    ack();
    do_eret();
    irq = '0;

    // Level channel 3 ignores W1C and re-requests
    irq = 8'h08;
    tick(4);
    check("lvl_req", {31'b0, int_req}, 1);
    check("lvl_cause", int_cause, 19);
    wr(2'd1, 32'h08);
    rd("lvl_w1c_kept", 2'd1, 32'h08);
    ack();
    rd("lvl_after_ack", 2'd1, 32'h08);
    do_eret();
    tick();
    check("lvl_repeat", {31'b0, int_req}, 1);
    check("lvl_repeat_cause", int_cause, 19);
    ack();
    irq = '0;
    wr(2'd0, 32'hF7);
    tick(3);
    do_eret();
    tick();
    check("lvl_quiet", {31'b0, int_req}, 0);
    rd("lvl_pend_gone", 2'd1, 0);

    // Masked channel 1 waits, then is taken when unmasked
    wr(2'd0, 32'h00);
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    tick(4);
    check("masked_no_req", {31'b0, int_req}, 0);
    rd("masked_pend", 2'd1, 32'h02);
    wr(2'd0, 32'h02);
    check("unmask_same", {31'b0, int_req}, 0);
    tick();
    check("unmask_req", {31'b0, int_req}, 1);
    check("unmask_cause", int_cause, 17);

    // GIE cleared while requesting withdraws the request
    wr(2'd2, 32'h00);
    check("gie_drop_req", {31'b0, int_req}, 0);
    check("gie_drop_cause", int_cause, 17);
    rd("gie_drop_pend", 2'd1, 32'h02);
    ack();
    rd("ack_idle_ignored", 2'd1, 32'h02);
    do_eret();
    rd("eret_idle_gie", 2'd2, 0);
    wr(2'd2, 32'h01);
    tick();
    check("gie_re_req", {31'b0, int_req}, 1);
    check("gie_re_cause", int_cause, 17);
    ack();

    // Asynchronous reset while in SERVICE
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    tick(3);
    rst = 1'b0;
    #1;
    check("arst_req", {31'b0, int_req}, 0);
    check("arst_cause", int_cause, 0);
    rd("arst_mask", 2'd0, 0);
    rd("arst_pend", 2'd1, 0);
    rd("arst_status", 2'd2, 0);
    rst = 1'b1;
    tick();
    wr(2'd0, 32'h02);
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    tick(4);
    check("post_rst_no_req", {31'b0, int_req}, 0);
    rd("post_rst_pend", 2'd1, 32'h02);
    wr(2'd2, 32'h01);
    check("post_rst_wait", {31'b0, int_req}, 0);
    tick();
    check("post_rst_req", {31'b0, int_req}, 1);
    check("post_rst_cause", int_cause, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
